// File: rtl/mlp_seq_pkg.sv
// Shared types and helpers for the MLP stream sequencer: FSM state encoding,
// default word width and counter sizing.
package mlp_seq_pkg;

  localparam int DATA_W_DFLT = 32;

  typedef enum logic [2:0] {
    LOAD_W = 3'd0,
    LOAD_X = 3'd1,
    RUN    = 3'd2,
    WAIT   = 3'd3,
    EMIT   = 3'd4
  } seq_state_e;

  // Bits needed to index 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mlp_seq_if.sv
// AXI-Stream style bundle (data/valid/last/ready) with master and slave views.
interface mlp_seq_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] TDATA;
  logic              TVALID;
  logic              TLAST;
  logic              TREADY;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);

endinterface

// File: rtl/mlp_seq_out_slot.sv
// Single-entry result holding register with valid/ready handshake and a TLAST bit;
// reset flushes any pending result.
module mlp_seq_out_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              pop
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    pop     = valid_q && out_ready;
    if (pop) begin
      valid_d = 1'b0;
    end
    // The controller only loads while the slot is empty, so load never races a pending word.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/mlp_seq_ctrl.sv
// Sequencer between AXI-Stream ports and the MLP datapath: loads weights, collects
// per-sample inputs, starts the core and emits results. Macro MLP_SEQ_WRELOAD_EN
// reloads weights before every batch.
module mlp_seq_ctrl
  import mlp_seq_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DFLT,
  parameter  int N_W    = 5,
  parameter  int N_X    = 2,
  parameter  int BATCH  = 64,
  localparam int AW     = cnt_w(max_i(N_W, N_X))
) (
  input  logic              ACLK,
  input  logic              ARESET,
  mlp_seq_if.slave          s_axis,
  mlp_seq_if.master         m_axis,
  output logic              dp_w_we,
  output logic              dp_x_we,
  output logic [AW-1:0]     dp_addr,
  output logic [DATA_W-1:0] dp_wdata,
  output logic              dp_start,
  input  logic              dp_done,
  input  logic [DATA_W-1:0] dp_result
);

  localparam int WCW = cnt_w(N_W);
  localparam int XCW = cnt_w(N_X);
  localparam int SCW = cnt_w(BATCH);

  localparam logic [WCW-1:0] W_LAST = WCW'(N_W - 1);
  localparam logic [XCW-1:0] X_LAST = XCW'(N_X - 1);
  localparam logic [SCW-1:0] S_LAST = SCW'(BATCH - 1);

`ifdef MLP_SEQ_WRELOAD_EN
  localparam bit WRELOAD = 1'b1;
`else
  localparam bit WRELOAD = 1'b0;
`endif

  seq_state_e state_q, state_d;

  logic [WCW-1:0]    w_cnt_q, w_cnt_d;
  logic [XCW-1:0]    x_cnt_q, x_cnt_d;
  logic [SCW-1:0]    sample_cnt_q, sample_cnt_d;
  logic              dp_w_we_q, dp_w_we_d;
  logic              dp_x_we_q, dp_x_we_d;
  logic [AW-1:0]     dp_addr_q, dp_addr_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
  logic              dp_start_q, dp_start_d;

  logic s_tready;
  logic s_beat;
  logic slot_load;
  logic slot_pop;
  logic unused_s_tlast;

  // Word counts come from parameters, so the incoming TLAST carries no information.
  assign unused_s_tlast = s_axis.TLAST;

  // Gated by reset so the slave never sees ready during a reset cycle.
  assign s_tready      = !ARESET && ((state_q == LOAD_W) || (state_q == LOAD_X));
  assign s_axis.TREADY = s_tready;
  assign s_beat        = s_tready && s_axis.TVALID;

  always_comb begin
    state_d      = state_q;
    w_cnt_d      = w_cnt_q;
    x_cnt_d      = x_cnt_q;
    sample_cnt_d = sample_cnt_q;
    dp_w_we_d    = 1'b0;
    dp_x_we_d    = 1'b0;
    dp_addr_d    = dp_addr_q;
    dp_wdata_d   = dp_wdata_q;
    dp_start_d   = 1'b0;
    slot_load    = 1'b0;

    case (state_q)
      LOAD_W: begin
        if (s_beat) begin
          dp_w_we_d  = 1'b1;
          dp_addr_d  = AW'(w_cnt_q);
          dp_wdata_d = s_axis.TDATA;
          if (w_cnt_q == W_LAST) begin
            w_cnt_d = '0;
            state_d = LOAD_X;
          end else begin
            w_cnt_d = w_cnt_q + 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (s_beat) begin
          dp_x_we_d  = 1'b1;
          dp_addr_d  = AW'(x_cnt_q);
          dp_wdata_d = s_axis.TDATA;
          if (x_cnt_q == X_LAST) begin
            x_cnt_d = '0;
            state_d = RUN;
          end else begin
            x_cnt_d = x_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        // Registered start lands the cycle after the final input write.
        dp_start_d = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (dp_done) begin
          slot_load = 1'b1;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (slot_pop) begin
          if (sample_cnt_q == S_LAST) begin
            sample_cnt_d = '0;
            state_d      = WRELOAD ? LOAD_W : LOAD_X;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            state_d      = LOAD_X;
          end
        end
      end
      default: begin
        state_d = LOAD_W;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= LOAD_W;
      w_cnt_q      <= '0;
      x_cnt_q      <= '0;
      sample_cnt_q <= '0;
      dp_w_we_q    <= 1'b0;
      dp_x_we_q    <= 1'b0;
      dp_addr_q    <= '0;
      dp_wdata_q   <= '0;
      dp_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_cnt_q      <= w_cnt_d;
      x_cnt_q      <= x_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      dp_w_we_q    <= dp_w_we_d;
      dp_x_we_q    <= dp_x_we_d;
      dp_addr_q    <= dp_addr_d;
      dp_wdata_q   <= dp_wdata_d;
      dp_start_q   <= dp_start_d;
    end
  end

  assign dp_w_we  = dp_w_we_q;
  assign dp_x_we  = dp_x_we_q;
  assign dp_addr  = dp_addr_q;
  assign dp_wdata = dp_wdata_q;
  assign dp_start = dp_start_q;

  mlp_seq_out_slot #(
    .DATA_W (DATA_W)
  ) u_out_slot (
    .clk       (ACLK),
    .rst       (ARESET),
    .load      (slot_load),
    .load_data (dp_result),
    .load_last (sample_cnt_q == S_LAST),
    .out_valid (m_axis.TVALID),
    .out_data  (m_axis.TDATA),
    .out_last  (m_axis.TLAST),
    .out_ready (m_axis.TREADY),
    .pop       (slot_pop)
  );

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Directed bench for mlp_seq_ctrl: weight load, sample flow, backpressure,
// batch TLAST, post-batch weight/input routing and mid-run reset.
module tb_mlp_seq_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        dp_w_we, dp_x_we, dp_start, dp_done;
  logic [2:0]  dp_addr;
  logic [31:0] dp_wdata, dp_result;

  int total = 0;
  int bad   = 0;

  mlp_seq_if #(.DATA_W(32)) s_if ();
  mlp_seq_if #(.DATA_W(32)) m_if ();

  mlp_seq_ctrl #(
    .DATA_W (32),
    .N_W    (5),
    .N_X    (2),
    .BATCH  (64)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .dp_w_we   (dp_w_we),
    .dp_x_we   (dp_x_we),
    .dp_addr   (dp_addr),
    .dp_wdata  (dp_wdata),
    .dp_start  (dp_start),
    .dp_done   (dp_done),
    .dp_result (dp_result)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One sample after the first: inputs with gaps, datapath delay, output backpressure.
  task automatic run_sample(input int idx);
    int gap;
    int dly;
    int hold;
    for (int k = 0; k < 2; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        chk("gap_no_xwe", {31'd0, dp_x_we}, 32'd0);
      end
      s_if.TVALID = 1'b1;
      s_if.TDATA  = 32'(idx * 2 + k);
      step();
      s_if.TVALID = 1'b0;
      chk("s_xwe", {31'd0, dp_x_we}, 32'd1);
      chk("s_xaddr", {29'd0, dp_addr}, 32'(k));
      chk("s_xdata", dp_wdata, 32'(idx * 2 + k));
    end
    chk("s_rdy_run", {31'd0, s_if.TREADY}, 32'd0);
    step();
    chk("s_start", {31'd0, dp_start}, 32'd1);
    dly = $urandom_range(0, 3);
    for (int d = 0; d < dly; d++) step();
    dp_done   = 1'b1;
    dp_result = 32'h100 + 32'(idx);
    step();
    dp_done = 1'b0;
    chk("s_mvalid", {31'd0, m_if.TVALID}, 32'd1);
    chk("s_mdata", m_if.TDATA, 32'h100 + 32'(idx));
    chk("s_mlast", {31'd0, m_if.TLAST}, (idx == 63) ? 32'd1 : 32'd0);
    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("s_hold", {31'd0, m_if.TVALID}, 32'd1);
    end
    m_if.TREADY = 1'b1;
    step();
    m_if.TREADY = 1'b0;
    chk("s_mdrop", {31'd0, m_if.TVALID}, 32'd0);
  endtask

  initial begin
    ARESET      = 1'b1;
    s_if.TDATA  = '0;
    s_if.TVALID = 1'b0;
    s_if.TLAST  = 1'b0;
    m_if.TREADY = 1'b0;
    dp_done     = 1'b0;
    dp_result   = '0;

    step();
    step();
    chk("rst_tready", {31'd0, s_if.TREADY}, 32'd0);
    chk("rst_mvalid", {31'd0, m_if.TVALID}, 32'd0);
    chk("rst_wwe", {31'd0, dp_w_we}, 32'd0);
    chk("rst_start", {31'd0, dp_start}, 32'd0);
    ARESET = 1'b0;
    #1;
    chk("loadw_tready", {31'd0, s_if.TREADY}, 32'd1);

    // Five weights back to back
    for (int i = 0; i < 5; i++) begin
      s_if.TVALID = 1'b1;
      s_if.TDATA  = 32'(i + 1);
      step();
      chk("w_we", {31'd0, dp_w_we}, 32'd1);
      chk("w_addr", {29'd0, dp_addr}, 32'(i));
      chk("w_data", dp_wdata, 32'(i + 1));
    end
    s_if.TVALID = 1'b0;
    step();
    chk("w_we_off", {31'd0, dp_w_we}, 32'd0);
    chk("loadx_tready", {31'd0, s_if.TREADY}, 32'd1);

    // Sample 0: x=(7,9), done three cycles after start, result 0x2A
    s_if.TVALID = 1'b1;
    s_if.TDATA  = 32'd7;
    step();
    chk("x0_we", {31'd0, dp_x_we}, 32'd1);
    chk("x0_wwe", {31'd0, dp_w_we}, 32'd0);
    chk("x0_addr", {29'd0, dp_addr}, 32'd0);
    chk("x0_data", dp_wdata, 32'd7);
    s_if.TDATA = 32'd9;
    step();
    s_if.TVALID = 1'b0;
    chk("x1_we", {31'd0, dp_x_we}, 32'd1);
    chk("x1_addr", {29'd0, dp_addr}, 32'd1);
    chk("x1_data", dp_wdata, 32'd9);
    chk("x1_nostart", {31'd0, dp_start}, 32'd0);
    chk("run_tready", {31'd0, s_if.TREADY}, 32'd0);
    step();
    chk("start_pulse", {31'd0, dp_start}, 32'd1);
    chk("start_xwe", {31'd0, dp_x_we}, 32'd0);
    step();
    chk("start_once", {31'd0, dp_start}, 32'd0);
    step();
    step();
    chk("wait_mvalid", {31'd0, m_if.TVALID}, 32'd0);
    chk("wait_tready", {31'd0, s_if.TREADY}, 32'd0);
    dp_done   = 1'b1;
    dp_result = 32'h2A;
    step();
    dp_done = 1'b0;
    chk("emit_valid", {31'd0, m_if.TVALID}, 32'd1);
    chk("emit_data", m_if.TDATA, 32'h2A);
    chk("emit_last", {31'd0, m_if.TLAST}, 32'd0);

    // Downstream stalls for ten cycles while the slave offers data
    s_if.TVALID = 1'b1;
    s_if.TDATA  = 32'h99;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", {31'd0, m_if.TVALID}, 32'd1);
      chk("bp_data", m_if.TDATA, 32'h2A);
      chk("bp_tready", {31'd0, s_if.TREADY}, 32'd0);
      chk("bp_xwe", {31'd0, dp_x_we}, 32'd0);
    end
    s_if.TVALID = 1'b0;
    m_if.TREADY = 1'b1;
    step();
    m_if.TREADY = 1'b0;
    chk("hs_drop", {31'd0, m_if.TVALID}, 32'd0);
    chk("hs_tready", {31'd0, s_if.TREADY}, 32'd1);

    // Stray done outside WAIT has no effect
    dp_done   = 1'b1;
    dp_result = 32'hBAD;
    step();
    dp_done = 1'b0;
    step();
    chk("stray_mvalid", {31'd0, m_if.TVALID}, 32'd0);
    chk("stray_tready", {31'd0, s_if.TREADY}, 32'd1);

    // Remaining 63 samples of the batch
    for (int s = 1; s < 64; s++) begin
      run_sample(s);
    end

    // First beat after the batch boundary
    s_if.TVALID = 1'b1;
    s_if.TDATA  = 32'hAB;
    step();
    s_if.TVALID = 1'b0;
`ifdef MLP_SEQ_WRELOAD_EN
    chk("post_wwe", {31'd0, dp_w_we}, 32'd1);
    chk("post_xwe", {31'd0, dp_x_we}, 32'd0);
    chk("post_addr", {29'd0, dp_addr}, 32'd0);
    chk("post_data", dp_wdata, 32'hAB);
    for (int i = 1; i < 5; i++) begin
      s_if.TVALID = 1'b1;
      s_if.TDATA  = 32'(i);
      step();
      chk("rl_wwe", {31'd0, dp_w_we}, 32'd1);
      chk("rl_addr", {29'd0, dp_addr}, 32'(i));
    end
    s_if.TDATA = 32'h11;
    step();
    chk("rl_x0", {31'd0, dp_x_we}, 32'd1);
`else
    chk("post_wwe", {31'd0, dp_w_we}, 32'd0);
    chk("post_xwe", {31'd0, dp_x_we}, 32'd1);
    chk("post_addr", {29'd0, dp_addr}, 32'd0);
    chk("post_data", dp_wdata, 32'hAB);
`endif
    s_if.TVALID = 1'b1;
    s_if.TDATA  = 32'h12;
    step();
    s_if.TVALID = 1'b0;
    chk("post_x1", {31'd0, dp_x_we}, 32'd1);
    chk("post_x1_addr", {29'd0, dp_addr}, 32'd1);
    step();
    chk("post_start", {31'd0, dp_start}, 32'd1);

    // Reset while waiting for the datapath, then a late done
    ARESET = 1'b1;
    step();
    chk("mid_rst_tready", {31'd0, s_if.TREADY}, 32'd0);
    ARESET = 1'b0;
    #1;
    chk("mid_rst_loadw", {31'd0, s_if.TREADY}, 32'd1);
    chk("mid_rst_start", {31'd0, dp_start}, 32'd0);
    dp_done   = 1'b1;
    dp_result = 32'hDEAD;
    step();
    dp_done = 1'b0;
    chk("late_done_mvalid", {31'd0, m_if.TVALID}, 32'd0);
    s_if.TVALID = 1'b1;
    s_if.TDATA  = 32'h55;
    step();
    s_if.TVALID = 1'b0;
    chk("rst_w_we", {31'd0, dp_w_we}, 32'd1);
    chk("rst_w_xwe", {31'd0, dp_x_we}, 32'd0);
    chk("rst_w_addr", {29'd0, dp_addr}, 32'd0);
    chk("rst_w_data", dp_wdata, 32'h55);
    step();
    chk("rst_mvalid_end", {31'd0, m_if.TVALID}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
